// File: rtl/mem_link_client.sv
// Memory-side link endpoint: deserializes wormhole command packets into memory
// command messages and serializes memory responses back to the command originator.
module mem_link_client #(
  parameter int unsigned flit_width_p          = 64,
  parameter int unsigned cord_width_p          = 8,
  parameter int unsigned cid_width_p           = 2,
  parameter int unsigned len_width_p           = 4,
  parameter int unsigned mem_msg_width_p       = 128,
  parameter int unsigned num_outstanding_req_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [flit_width_p+1:0]    cmd_link_i,
  output logic [flit_width_p+1:0]    resp_link_o,
  output logic [mem_msg_width_p-1:0] mem_cmd_o,
  output logic                       mem_cmd_v_o,
  input  logic                       mem_cmd_yumi_i,
  input  logic [mem_msg_width_p-1:0] mem_resp_i,
  input  logic                       mem_resp_v_i,
  output logic                       mem_resp_ready_o
);

  localparam int unsigned HDR_W     = 2*cord_width_p + len_width_p + 2*cid_width_p;
  localparam int unsigned PKT_W     = HDR_W + mem_msg_width_p;
  localparam int unsigned NUM_FLITS = (PKT_W + flit_width_p - 1) / flit_width_p;
  localparam int unsigned PAD_W     = NUM_FLITS * flit_width_p;
  localparam int unsigned SRC_W     = cord_width_p + cid_width_p;
  localparam int unsigned PTR_W     = (num_outstanding_req_p > 1) ? $clog2(num_outstanding_req_p) : 1;
  localparam int unsigned CNT_W     = $clog2(num_outstanding_req_p + 1);
  localparam int unsigned SRC_OFS   = cord_width_p + len_width_p + cid_width_p;
  localparam logic [len_width_p-1:0] RESP_LEN = len_width_p'(NUM_FLITS - 1);

  typedef enum logic [1:0] {C_IDLE, C_RECV, C_FULL} cmd_state_e;
  typedef enum logic       {R_IDLE, R_SEND}         resp_state_e;

  cmd_state_e  cmd_state, cmd_state_next;
  resp_state_e resp_state, resp_state_next;

  logic                    init_r;
  logic                    cmd_v, cmd_ready, cmd_acc, hdr_push;
  logic [flit_width_p-1:0] cmd_data;
  logic [len_width_p-1:0]  hdr_len, cmd_len_r, cmd_cnt, cmd_idx;
  logic [mem_msg_width_p-1:0] cmd_msg_r;

  logic                    resp_v, resp_ready, resp_acc, resp_xfer, resp_last, hdr_pop;
  logic [flit_width_p-1:0] resp_data;
  logic [len_width_p-1:0]  resp_idx;
  logic [PAD_W-1:0]        resp_pkt_r;

  logic [SRC_W-1:0]        fifo_mem [num_outstanding_req_p];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;
  logic                    fifo_full, fifo_empty;
  logic [SRC_W-1:0]        fifo_head;
  logic [cord_width_p-1:0] head_cord;
  logic [cid_width_p-1:0]  head_cid;

  assign cmd_v       = cmd_link_i[flit_width_p+1];
  assign cmd_data    = cmd_link_i[flit_width_p:1];
  assign resp_ready  = cmd_link_i[0];
  assign resp_link_o = {resp_v, resp_data, cmd_ready};

  // Holds ready low through the first clock after reset release.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) init_r <= 1'b1;
    else         init_r <= 1'b0;
  end

  // ---------------- command receive ----------------
  assign hdr_len   = cmd_data[cord_width_p +: len_width_p];
  assign cmd_ready = ~reset_i & ~init_r & (cmd_state != C_FULL)
                   & ((cmd_state == C_RECV) | ~fifo_full);
  assign cmd_acc   = cmd_v & cmd_ready;
  assign hdr_push  = cmd_acc & (cmd_state == C_IDLE);
  assign cmd_idx   = (cmd_state == C_IDLE) ? '0 : cmd_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cmd_state <= C_IDLE;
    else         cmd_state <= cmd_state_next;
  end

  always_comb begin
    cmd_state_next = cmd_state;
    case (cmd_state)
      C_IDLE: if (cmd_acc) cmd_state_next = (hdr_len == '0) ? C_FULL : C_RECV;
      C_RECV: if (cmd_acc && cmd_cnt == cmd_len_r) cmd_state_next = C_FULL;
      C_FULL: if (mem_cmd_yumi_i) cmd_state_next = C_IDLE;
      default: cmd_state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_len_r <= '0;
      cmd_cnt   <= '0;
      cmd_msg_r <= '0;
    end else if (cmd_acc) begin
      if (cmd_state == C_IDLE) begin
        cmd_len_r <= hdr_len;
        cmd_cnt   <= len_width_p'(1);
      end else begin
        cmd_cnt   <= cmd_cnt + len_width_p'(1);
      end
      // Only message bits are stored; each lands from the flit that carries it.
      for (int unsigned b = 0; b < mem_msg_width_p; b++) begin
        if (cmd_idx == len_width_p'((HDR_W + b) / flit_width_p))
          cmd_msg_r[b] <= cmd_data[(HDR_W + b) % flit_width_p];
      end
    end
  end

  assign mem_cmd_v_o = (cmd_state == C_FULL);
  assign mem_cmd_o   = cmd_msg_r;

  // ---------------- source tracking FIFO ----------------
  assign fifo_full  = (fifo_cnt == CNT_W'(num_outstanding_req_p));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign head_cord  = fifo_head[cid_width_p +: cord_width_p];
  assign head_cid   = fifo_head[cid_width_p-1:0];

  always_ff @(posedge clk_i) begin
    if (hdr_push)
      fifo_mem[wr_ptr] <= {cmd_data[SRC_OFS +: cord_width_p],
                           cmd_data[SRC_OFS + cord_width_p +: cid_width_p]};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (hdr_push)
        wr_ptr <= (wr_ptr == PTR_W'(num_outstanding_req_p - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (hdr_pop)
        rd_ptr <= (rd_ptr == PTR_W'(num_outstanding_req_p - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({hdr_push, hdr_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- response send ----------------
  assign mem_resp_ready_o = (resp_state == R_IDLE) & ~fifo_empty & ~init_r;
  assign resp_acc  = mem_resp_v_i & mem_resp_ready_o;
  assign resp_v    = (resp_state == R_SEND);
  assign resp_xfer = resp_v & resp_ready;
  assign resp_last = (resp_idx == RESP_LEN);
  // The originator entry retires once its header flit has left.
  assign hdr_pop   = resp_xfer & (resp_idx == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) resp_state <= R_IDLE;
    else         resp_state <= resp_state_next;
  end

  always_comb begin
    resp_state_next = resp_state;
    case (resp_state)
      R_IDLE: if (resp_acc) resp_state_next = R_SEND;
      R_SEND: if (resp_xfer && resp_last) resp_state_next = R_IDLE;
      default: resp_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_pkt_r <= '0;
      resp_idx   <= '0;
    end else if (resp_acc) begin
      resp_pkt_r <= PAD_W'({mem_resp_i, {SRC_W{1'b0}}, head_cid, RESP_LEN, head_cord});
      resp_idx   <= '0;
    end else if (resp_xfer) begin
      resp_idx   <= resp_idx + len_width_p'(1);
    end
  end

  always_comb begin
    resp_data = '0;
    for (int unsigned i = 0; i < NUM_FLITS; i++) begin
      if (resp_idx == len_width_p'(i))
        resp_data = resp_pkt_r[i*flit_width_p +: flit_width_p];
    end
  end

endmodule

// File: tb/tb_mem_link_client.sv
// Directed-plus-random bench for mem_link_client against a queue-based packet model.
module tb_mem_link_client;
  localparam int FW = 64, CW = 8, IW = 2, LW = 4, MW = 128, NO = 8;
  localparam int NF = 3;
  localparam int PW = NF * FW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [FW+1:0] cmd_link_i, resp_link_o;
  logic [MW-1:0] mem_cmd_o, mem_resp_i;
  logic          mem_cmd_v_o, mem_cmd_yumi_i, mem_resp_v_i, mem_resp_ready_o;

  logic          cmd_v, resp_rdy;
  logic [FW-1:0] cmd_data;
  logic          resp_v, cmd_rdy;
  logic [FW-1:0] resp_data;

  assign cmd_link_i = {cmd_v, cmd_data, resp_rdy};
  assign resp_v     = resp_link_o[FW+1];
  assign resp_data  = resp_link_o[FW:1];
  assign cmd_rdy    = resp_link_o[0];

  mem_link_client #(
    .flit_width_p(FW), .cord_width_p(CW), .cid_width_p(IW), .len_width_p(LW),
    .mem_msg_width_p(MW), .num_outstanding_req_p(NO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_link_i(cmd_link_i), .resp_link_o(resp_link_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [CW+IW-1:0] src_q[$];

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] make_pkt(input int cord, input int len, input int cid,
                                             input int scord, input int scid, input logic [MW-1:0] msg);
    logic [PW-1:0] p;
    p = PW'(msg);
    p = (p << IW) | PW'(scid);
    p = (p << CW) | PW'(scord);
    p = (p << IW) | PW'(cid);
    p = (p << LW) | PW'(len);
    p = (p << CW) | PW'(cord);
    return p;
  endfunction

  function automatic logic [FW-1:0] flit_of(input logic [PW-1:0] p, input int i);
    return FW'(p >> (i * FW));
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_flit(input logic [FW-1:0] d, input string tag);
    int n;
    n = 0;
    cmd_v = 1'b1; cmd_data = d; #1;
    while (cmd_rdy !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
    check({tag, " accept"}, PW'(cmd_rdy), PW'(1'b1));
    @(negedge clk);
    cmd_v = 1'b0;
  endtask

  task automatic send_cmd(input int cord, input int cid, input int scord, input int scid,
                          input logic [MW-1:0] msg, input string tag);
    logic [PW-1:0] p;
    p = make_pkt(cord, NF - 1, cid, scord, scid, msg);
    src_q.push_back({CW'(scord), IW'(scid)});
    for (int i = 0; i < NF; i++) begin
      if (i == NF - 1) begin #1; check({tag, " cmd_v early"}, PW'(mem_cmd_v_o), '0); end
      send_flit(flit_of(p, i), tag);
    end
    #1;
    check({tag, " cmd_v"}, PW'(mem_cmd_v_o), PW'(1'b1));
    check({tag, " cmd_msg"}, PW'(mem_cmd_o), PW'(msg));
  endtask

  task automatic yumi(input string tag);
    mem_cmd_yumi_i = 1'b1;
    @(negedge clk);
    mem_cmd_yumi_i = 1'b0; #1;
    check({tag, " cmd_v after yumi"}, PW'(mem_cmd_v_o), '0);
  endtask

  task automatic recv_resp(input logic [PW-1:0] exp, input int stall_at, input int stall_len,
                           input string tag);
    logic [PW-1:0] got;
    got = '0;
    for (int f = 0; f < NF; f++) begin
      #1;
      if (f == stall_at) begin
        resp_rdy = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk); #1;
          check({tag, " stall v"}, PW'(resp_v), PW'(1'b1));
          check({tag, " stall data"}, PW'(resp_data), PW'(flit_of(exp, f)));
          check({tag, " stall mem_resp_ready"}, PW'(mem_resp_ready_o), '0);
        end
        resp_rdy = 1'b1;
      end
      check({tag, " flit v"}, PW'(resp_v), PW'(1'b1));
      check({tag, " mem_resp_ready busy"}, PW'(mem_resp_ready_o), '0);
      got = got | (PW'(resp_data) << (f * FW));
      @(negedge clk);
    end
    #1;
    check({tag, " packet"}, got, exp);
    check({tag, " v after last"}, PW'(resp_v), '0);
  endtask

  task automatic do_resp(input logic [MW-1:0] msg, input int stall_at, input int stall_len,
                         input string tag);
    logic [CW+IW-1:0] s;
    logic [PW-1:0] exp;
    int n;
    s = src_q.pop_front();
    exp = make_pkt(int'(s[IW +: CW]), NF - 1, int'(s[IW-1:0]), 0, 0, msg);
    mem_resp_i = msg; mem_resp_v_i = 1'b1; #1;
    n = 0;
    while (mem_resp_ready_o !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
    check({tag, " resp accept"}, PW'(mem_resp_ready_o), PW'(1'b1));
    @(negedge clk);
    mem_resp_v_i = 1'b0;
    recv_resp(exp, stall_at, stall_len, tag);
    check({tag, " mem_resp_ready after"}, PW'(mem_resp_ready_o), PW'(src_q.size() != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] m;
    logic [PW-1:0] p9, ea;
    logic [CW+IW-1:0] s;
    int sc9, si9;

    reset_i = 1'b1; cmd_v = 1'b0; cmd_data = '0; resp_rdy = 1'b1;
    mem_cmd_yumi_i = 1'b0; mem_resp_i = '0; mem_resp_v_i = 1'b0;
    #1;
    check("reset cmd_rdy", PW'(cmd_rdy), '0);
    check("reset resp_v", PW'(resp_v), '0);
    check("reset mem_cmd_v", PW'(mem_cmd_v_o), '0);
    check("reset mem_resp_ready", PW'(mem_resp_ready_o), '0);
    repeat (3) @(negedge clk);
    reset_i = 1'b0; #1;
    check("post-reset cmd_rdy", PW'(cmd_rdy), '0);
    check("post-reset mem_resp_ready", PW'(mem_resp_ready_o), '0);
    @(negedge clk); #1;
    check("idle cmd_rdy", PW'(cmd_rdy), PW'(1'b1));
    @(negedge clk);

    // Single command and round trip
    m = {32'hDEADBEEF, $urandom, $urandom, $urandom};
    send_cmd(1, 0, 8'hFF, 1, m, "single");
    yumi("single");
    do_resp(128'h1234, -1, 0, "roundtrip");

    // Backpressure mid-response
    send_cmd($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 255),
             $urandom_range(0, 3), rand_msg(), "bp");
    yumi("bp");
    do_resp(rand_msg(), 1, 5, "bp");

    // Credit limit: fill tracking FIFO, ninth header stalls
    for (int i = 0; i < NO; i++) begin
      send_cmd($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 255),
               $urandom_range(0, 3), rand_msg(), "credit");
      yumi("credit");
    end
    sc9 = $urandom_range(0, 255); si9 = $urandom_range(0, 3); m = rand_msg();
    p9 = make_pkt(2, NF - 1, 0, sc9, si9, m);
    cmd_v = 1'b1; cmd_data = flit_of(p9, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("credit hdr stalled", PW'(cmd_rdy), '0);
    end
    check("credit resp_ready", PW'(mem_resp_ready_o), PW'(1'b1));
    s = src_q.pop_front();
    ea = make_pkt(int'(s[IW +: CW]), NF - 1, int'(s[IW-1:0]), 0, 0, 128'hABCD);
    mem_resp_i = 128'hABCD; mem_resp_v_i = 1'b1;
    @(negedge clk);
    mem_resp_v_i = 1'b0; #1;
    check("credit f0", PW'(resp_data), PW'(flit_of(ea, 0)));
    check("credit stall at f0", PW'(cmd_rdy), '0);
    @(negedge clk); #1;
    check("credit f1", PW'(resp_data), PW'(flit_of(ea, 1)));
    check("credit ready after pop", PW'(cmd_rdy), PW'(1'b1));
    @(negedge clk);
    src_q.push_back({CW'(sc9), IW'(si9)});
    cmd_data = flit_of(p9, 1); #1;
    check("credit f2", PW'(resp_data), PW'(flit_of(ea, 2)));
    @(negedge clk);
    cmd_data = flit_of(p9, 2); #1;
    check("credit resp done", PW'(resp_v), '0);
    check("credit body rdy", PW'(cmd_rdy), PW'(1'b1));
    @(negedge clk);
    cmd_v = 1'b0; #1;
    check("credit 9th v", PW'(mem_cmd_v_o), PW'(1'b1));
    check("credit 9th msg", PW'(mem_cmd_o), PW'(m));
    yumi("credit9");
    while (src_q.size() != 0) do_resp(rand_msg(), -1, 0, "drain");

    // Ordering
    send_cmd(4, 1, 3, $urandom_range(0, 3), rand_msg(), "order");
    yumi("order");
    send_cmd(4, 1, 5, $urandom_range(0, 3), rand_msg(), "order");
    yumi("order");
    send_cmd(4, 1, 7, $urandom_range(0, 3), rand_msg(), "order");
    yumi("order");
    for (int i = 0; i < 3; i++) begin
      check("order expected cord", PW'(src_q[0][IW +: CW]), PW'(3 + 2 * i));
      do_resp(rand_msg(), -1, 0, "order");
    end

    // Reset mid-packet
    ea = make_pkt(9, NF - 1, 0, 8'h42, 2, rand_msg());
    send_flit(flit_of(ea, 0), "rst");
    send_flit(flit_of(ea, 1), "rst");
    reset_i = 1'b1; #1;
    src_q.delete();
    check("rst cmd_rdy", PW'(cmd_rdy), '0);
    check("rst resp_v", PW'(resp_v), '0);
    check("rst mem_cmd_v", PW'(mem_cmd_v_o), '0);
    check("rst mem_resp_ready", PW'(mem_resp_ready_o), '0);
    @(negedge clk);
    reset_i = 1'b0; #1;
    check("rst release cmd_rdy", PW'(cmd_rdy), '0);
    @(negedge clk);
    send_cmd(6, 2, $urandom_range(0, 255), $urandom_range(0, 3), rand_msg(), "fresh");
    yumi("fresh");
    do_resp(rand_msg(), 0, 2, "fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
